// File: rtl/wgt_buf_writer.sv
// Weight buffer fill stage: packs IN_W-bit stream beats into TN x INT8 rows,
// writes them into the current ping/pong bank and tracks per-bank ownership.
// Optional macro WGT_WR_PERF_CNT_EN adds the stall_cnt output and its counter.
module wgt_buf_writer #(
  parameter int TN         = 14,
  parameter int ADDR_WIDTH = 7,
  parameter int IN_W       = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_rows,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [IN_W-1:0]       s_data,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [TN*8-1:0]       wdata,
  output logic                  bank_sel_wr,
  output logic [1:0]            bank_full,
  input  logic                  release_req,
  input  logic                  release_bank,
  output logic                  busy,
  output logic                  done,
  output logic                  err
`ifdef WGT_WR_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  localparam int RW  = TN * 8;
  localparam int BPR = (RW + IN_W - 1) / IN_W;
  localparam int PW  = BPR * IN_W;
  localparam int BW  = (BPR > 1) ? $clog2(BPR) : 1;

  localparam logic [BW-1:0]         LAST_BEAT = BW'(BPR - 1);
  localparam logic [BW-1:0]         BEAT_ONE  = BW'(1);
  localparam logic [ADDR_WIDTH:0]   ROW_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0]   MAX_ROWS  = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BANK = 2'd1,
    FILL      = 2'd2,
    COMMIT    = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic                  wr_bank_q, wr_bank_d;
  logic [1:0]            bank_full_q, bank_full_d;
  logic [ADDR_WIDTH:0]   rows_q, rows_d;
  logic [ADDR_WIDTH:0]   row_cnt_q, row_cnt_d;
  logic [BW-1:0]         beat_cnt_q, beat_cnt_d;
  logic [PW-1:0]         pack_q, pack_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [RW-1:0]         wdata_q, wdata_d;
  logic                  bank_sel_q, bank_sel_d;
  logic                  err_q, err_d;

  logic                  commit;
  logic                  start_legal;
  logic [PW-1:0]         row_next;

  assign start_legal = (num_rows != '0) && (num_rows <= MAX_ROWS);
  assign commit      = (state_q == COMMIT);

  // Next-state logic: tile sequencing, beat packing, row writes and bank ownership.
  always_comb begin
    state_d     = state_q;
    wr_bank_d   = wr_bank_q;
    bank_full_d = bank_full_q;
    rows_d      = rows_q;
    row_cnt_d   = row_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    pack_d      = pack_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    bank_sel_d  = bank_sel_q;
    err_d       = err_q;

    row_next = pack_q;
    for (int b = 0; b < BPR; b++) begin
      if (beat_cnt_q == BW'(b)) begin
        row_next[b*IN_W +: IN_W] = s_data;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (start_legal) begin
            rows_d     = num_rows;
            row_cnt_d  = '0;
            beat_cnt_d = '0;
            state_d    = bank_full_q[wr_bank_q] ? WAIT_BANK : FILL;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      WAIT_BANK: begin
        if (!bank_full_q[wr_bank_q]) begin
          state_d = FILL;
        end
      end
      FILL: begin
        if (s_valid) begin
          pack_d = row_next;
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = '0;
            we_d       = 1'b1;
            waddr_d    = row_cnt_q[ADDR_WIDTH-1:0];
            wdata_d    = row_next[RW-1:0];
            bank_sel_d = wr_bank_q;
            row_cnt_d  = row_cnt_q + ROW_ONE;
            if ((row_cnt_q + ROW_ONE) == rows_q) begin
              state_d = COMMIT;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_ONE;
          end
        end
      end
      COMMIT: begin
        wr_bank_d = ~wr_bank_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A release colliding with the commit of the same bank is not an error.
    if (release_req) begin
      if (!bank_full_q[release_bank] && !(commit && (wr_bank_q == release_bank))) begin
        err_d = 1'b1;
      end
      bank_full_d[release_bank] = 1'b0;
    end
    if (commit) begin
      bank_full_d[wr_bank_q] = 1'b1;
    end
  end

  // State and datapath registers; reset aborts any tile in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_bank_q   <= 1'b0;
      bank_full_q <= 2'b00;
      rows_q      <= '0;
      row_cnt_q   <= '0;
      beat_cnt_q  <= '0;
      pack_q      <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      bank_sel_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_bank_q   <= wr_bank_d;
      bank_full_q <= bank_full_d;
      rows_q      <= rows_d;
      row_cnt_q   <= row_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      pack_q      <= pack_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      bank_sel_q  <= bank_sel_d;
      err_q       <= err_d;
    end
  end

  assign s_ready     = (state_q == FILL);
  assign busy        = (state_q != IDLE);
  assign done        = commit;
  assign we          = we_q;
  assign waddr       = waddr_q;
  assign wdata       = wdata_q;
  assign bank_sel_wr = bank_sel_q;
  assign bank_full   = bank_full_q;
  assign err         = err_q;

`ifdef WGT_WR_PERF_CNT_EN
  logic [31:0] stall_q, stall_d;

  assign stall_d = (((state_q == WAIT_BANK) || ((state_q == FILL) && !s_valid)) && (stall_q != 32'hFFFF_FFFF))
                   ? stall_q + 32'd1 : stall_q;

  // Saturating count of cycles spent waiting for a bank or starved of beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_wgt_buf_writer.sv
// Self-checking bench for wgt_buf_writer: a byte-queue reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_wgt_buf_writer;

  localparam int TN    = 14;
  localparam int AW    = 7;
  localparam int IN_W  = 64;
  localparam int RW    = TN * 8;
  localparam int BPB   = IN_W / 8;
  localparam int BPR   = (RW + IN_W - 1) / IN_W;
  localparam int DEPTH = 1 << AW;

  localparam int M_IDLE   = 0;
  localparam int M_WAIT   = 1;
  localparam int M_FILL   = 2;
  localparam int M_COMMIT = 3;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [AW:0]     num_rows;
  logic            s_valid;
  logic            s_ready;
  logic [IN_W-1:0] s_data;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [RW-1:0]   wdata;
  logic            bank_sel_wr;
  logic [1:0]      bank_full;
  logic            release_req;
  logic            release_bank;
  logic            busy;
  logic            done;
  logic            err;
`ifdef WGT_WR_PERF_CNT_EN
  logic [31:0]     stall_cnt;
`endif

  wgt_buf_writer #(.TN(TN), .ADDR_WIDTH(AW), .IN_W(IN_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_rows     (num_rows),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .we           (we),
    .waddr        (waddr),
    .wdata        (wdata),
    .bank_sel_wr  (bank_sel_wr),
    .bank_full    (bank_full),
    .release_req  (release_req),
    .release_bank (release_bank),
    .busy         (busy),
    .done         (done),
    .err          (err)
`ifdef WGT_WR_PERF_CNT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int doneCnt = 0;
  int lastDoneCyc = -1;

  typedef struct {
    int            c;
    logic [AW-1:0] a;
    logic [RW-1:0] d;
    logic          b;
  } wr_t;
  wr_t wlog[$];

  // Reference model state
  int          mMode = M_IDLE;
  int          mTileRows = 0;
  int          mRows = 0;
  bit          mBank = 1'b0;
  logic [1:0]  mFull = 2'b00;
  bit          mErr = 1'b0;
  logic [31:0] mStall = '0;
  logic [7:0]  mBytes[$];
  logic          eWe = 1'b0;
  logic [AW-1:0] eAddr = '0;
  logic [RW-1:0] eData = '0;
  logic          eBankSel = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle counter used to time-stamp observations.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: stream bytes are queued and a row is emitted once a full
  // row's worth of beats has arrived, taking the first TN bytes.
  always @(posedge clk or negedge rst_n) begin
    bit commitNow;
    int nr;
    logic [RW-1:0] row;
    if (!rst_n) begin
      mMode = M_IDLE; mTileRows = 0; mRows = 0; mBank = 1'b0; mFull = 2'b00;
      mErr = 1'b0; mStall = '0; mBytes.delete();
      eWe = 1'b0; eAddr = '0; eData = '0; eBankSel = 1'b0;
    end else begin
      commitNow = (mMode == M_COMMIT);
      eWe = 1'b0;
      if ((mMode == M_WAIT) || (mMode == M_FILL && !s_valid)) begin
        if (mStall != 32'hFFFF_FFFF) mStall = mStall + 32'd1;
      end
      case (mMode)
        M_IDLE: begin
          if (start) begin
            nr = int'(num_rows);
            if (nr >= 1 && nr <= DEPTH) begin
              mTileRows = nr;
              mRows = 0;
              mBytes.delete();
              mMode = mFull[mBank] ? M_WAIT : M_FILL;
            end else begin
              mErr = 1'b1;
            end
          end
        end
        M_WAIT: if (!mFull[mBank]) mMode = M_FILL;
        M_FILL: begin
          if (s_valid) begin
            for (int k = 0; k < BPB; k++) mBytes.push_back(s_data[8*k +: 8]);
            if (mBytes.size() == BPR * BPB) begin
              row = '0;
              for (int i = 0; i < TN; i++) row[8*i +: 8] = mBytes[i];
              mBytes.delete();
              eWe = 1'b1;
              eAddr = AW'(mRows);
              eData = row;
              eBankSel = mBank;
              mRows++;
              if (mRows == mTileRows) mMode = M_COMMIT;
            end
          end
        end
        default: mMode = M_IDLE;
      endcase
      if (release_req) begin
        if (!mFull[release_bank] && !(commitNow && (mBank == release_bank))) mErr = 1'b1;
        mFull[release_bank] = 1'b0;
      end
      if (commitNow) begin
        mFull[mBank] = 1'b1;
        mBank = ~mBank;
      end
    end
  end

  // Compare DUT against the model every cycle and log observed writes.
  always @(negedge clk) begin
    wr_t e;
    checkOutput("we", 128'(we), 128'(eWe));
    checkOutput("s_ready", 128'(s_ready), 128'(mMode == M_FILL));
    checkOutput("busy", 128'(busy), 128'(mMode != M_IDLE));
    checkOutput("done", 128'(done), 128'(mMode == M_COMMIT));
    checkOutput("err", 128'(err), 128'(mErr));
    checkOutput("bank_full", 128'(bank_full), 128'(mFull));
    checkOutput("bank_sel_wr", 128'(bank_sel_wr), 128'(eBankSel));
    if (eWe) begin
      checkOutput("waddr", 128'(waddr), 128'(eAddr));
      checkOutput("wdata", 128'(wdata), 128'(eData));
    end
`ifdef WGT_WR_PERF_CNT_EN
    checkOutput("stall_cnt", 128'(stall_cnt), 128'(mStall));
`endif
    if (we) begin
      e.c = cyc; e.a = waddr; e.d = wdata; e.b = bank_sel_wr;
      wlog.push_back(e);
    end
    if (done) begin
      doneCnt++;
      lastDoneCyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the control inputs for one cycle, then return them to idle.
  task automatic applyStimulus(input logic st, input logic [AW:0] nr, input logic rr, input logic rb);
    start = st; num_rows = nr; release_req = rr; release_bank = rb;
    tick();
    start = 1'b0; release_req = 1'b0;
  endtask

  // Present one beat until it is taken; pc returns the cycle it was taken in.
  task automatic sendBeat(input logic [IN_W-1:0] d, output int pc);
    bit rdy;
    int n;
    rdy = 1'b0; n = 0; pc = -1;
    s_valid = 1'b1; s_data = d;
    while (!rdy && n < 300) begin
      @(negedge clk);
      rdy = s_ready;
      pc = cyc;
      tick();
      n++;
    end
    s_valid = 1'b0;
    if (!rdy) checkOutput("beat_timeout", 128'(rdy), 128'(1));
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  function automatic logic [IN_W-1:0] seqBeat(input int firstByte);
    logic [IN_W-1:0] d;
    for (int b = 0; b < BPB; b++) d[8*b +: 8] = 8'(firstByte + b);
    return d;
  endfunction

  initial begin
    int pc, b0, base, dBase, lastPc;
    logic [31:0] st0;
    start = 1'b0; num_rows = '0; s_valid = 1'b0; s_data = '0;
    release_req = 1'b0; release_bank = 1'b0; rst_n = 1'b0;
    repeat (3) tick();
    checkOutput("rst_we", 128'(we), 128'(0));
    checkOutput("rst_waddr", 128'(waddr), 128'(0));
    checkOutput("rst_wdata", 128'(wdata), 128'(0));
    checkOutput("rst_bank_full", 128'(bank_full), 128'(0));
    checkOutput("rst_busy_done_err", 128'({busy, done, err, s_ready, bank_sel_wr}), 128'(0));
    rst_n = 1'b1;
    tick();

    $display("[TB] basic fill");
    base = wlog.size(); dBase = doneCnt;
    applyStimulus(1'b1, 8'd3, 1'b0, 1'b0);
    b0 = 0;
    for (int k = 0; k < 6; k++) begin
      sendBeat(seqBeat(8 * k), pc);
      if (k == 0) b0 = pc;
    end
    repeat (3) tick();
    checkOutput("basic_nwrites", 128'(wlog.size() - base), 128'(3));
    if (wlog.size() >= base + 3) begin
      for (int i = 0; i < 3; i++) begin
        checkOutput("basic_we_cycle", 128'(wlog[base+i].c - b0), 128'(2 * (i + 1)));
        checkOutput("basic_waddr", 128'(wlog[base+i].a), 128'(i));
        checkOutput("basic_bank", 128'(wlog[base+i].b), 128'(0));
      end
      checkOutput("basic_row0", 128'(wlog[base].d), 128'(112'h0D0C0B0A09080706050403020100));
      checkOutput("basic_row2", 128'(wlog[base+2].d), 128'(112'h2D2C2B2A29282726252423222120));
      checkOutput("basic_done_align", 128'(lastDoneCyc), 128'(wlog[base+2].c));
    end
    checkOutput("basic_done_once", 128'(doneCnt - dBase), 128'(1));
    checkOutput("basic_bank_full", 128'(bank_full), 128'(2'b01));

    $display("[TB] ping-pong");
    base = wlog.size();
    applyStimulus(1'b1, 8'd1, 1'b0, 1'b0);
    sendBeat(64'h0123_4567_89AB_CDEF, pc);
    sendBeat(64'hFEDC_BA98_7654_3210, pc);
    repeat (3) tick();
    checkOutput("pp_nwrites", 128'(wlog.size() - base), 128'(1));
    if (wlog.size() > base) checkOutput("pp_bank", 128'(wlog[base].b), 128'(1));
    checkOutput("pp_bank_full", 128'(bank_full), 128'(2'b11));

    base = wlog.size();
    applyStimulus(1'b1, 8'd1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("wait_s_ready", 128'(s_ready), 128'(0));
      checkOutput("wait_busy", 128'(busy), 128'(1));
    end
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
    sendBeat(64'h1111_2222_3333_4444, pc);
    sendBeat(64'h5555_6666_7777_8888, pc);
    repeat (3) tick();
    checkOutput("wait_nwrites", 128'(wlog.size() - base), 128'(1));
    if (wlog.size() > base) checkOutput("wait_bank", 128'(wlog[base].b), 128'(0));
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
    tick();
    checkOutput("release_all", 128'({err, bank_full}), 128'(0));

    $display("[TB] stall");
    base = wlog.size();
    applyStimulus(1'b1, 8'd1, 1'b0, 1'b0);
`ifdef WGT_WR_PERF_CNT_EN
    st0 = stall_cnt;
`else
    st0 = '0;
`endif
    sendBeat(64'h8877_6655_4433_2211, pc);
    repeat (5) tick();
    sendBeat(64'hFFEE_DDCC_BBAA_9988, lastPc);
    repeat (3) tick();
    checkOutput("stall_nwrites", 128'(wlog.size() - base), 128'(1));
    if (wlog.size() > base) begin
      checkOutput("stall_row", 128'(wlog[base].d), 128'(112'hDDCCBBAA998888776655443322_11));
      checkOutput("stall_latency", 128'(wlog[base].c - lastPc), 128'(1));
      checkOutput("stall_bank", 128'(wlog[base].b), 128'(1));
    end
`ifdef WGT_WR_PERF_CNT_EN
    checkOutput("stall_cnt_delta", 128'(stall_cnt - st0), 128'(5));
`endif

    $display("[TB] errors");
    doReset();
    base = wlog.size();
    applyStimulus(1'b1, 8'd0, 1'b0, 1'b0);
    tick();
    checkOutput("err_zero_rows", 128'(err), 128'(1));
    checkOutput("err_zero_busy", 128'(busy), 128'(0));
    tick();
    checkOutput("err_zero_no_we", 128'(wlog.size() - base), 128'(0));
    doReset();
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1);
    tick();
    checkOutput("err_release_empty", 128'(err), 128'(1));
    checkOutput("err_release_flags", 128'(bank_full), 128'(2'b00));
    doReset();
    applyStimulus(1'b1, 8'd129, 1'b0, 1'b0);
    tick();
    checkOutput("err_129_rows", 128'({err, busy}), 128'(2'b10));
    doReset();

    $display("[TB] full tile");
    base = wlog.size(); dBase = doneCnt;
    applyStimulus(1'b1, 8'd128, 1'b0, 1'b0);
    for (int j = 0; j < 2 * DEPTH; j++) sendBeat({BPB{8'(j)}}, pc);
    repeat (3) tick();
    checkOutput("full_nwrites", 128'(wlog.size() - base), 128'(128));
    if (wlog.size() >= base + 128) begin
      for (int i = 0; i < 128; i++) checkOutput("full_waddr", 128'(wlog[base+i].a), 128'(i));
      checkOutput("full_last_addr", 128'(wlog[base+127].a), 128'(127));
      checkOutput("full_done_align", 128'(lastDoneCyc), 128'(wlog[base+127].c));
    end
    checkOutput("full_done_once", 128'(doneCnt - dBase), 128'(1));
    checkOutput("full_bank_full", 128'(bank_full), 128'(2'b01));

    $display("[TB] release/commit collision");
    applyStimulus(1'b1, 8'd1, 1'b0, 1'b0);
    sendBeat(64'hAAAA_AAAA_AAAA_AAAA, pc);
    sendBeat(64'h5555_5555_5555_5555, pc);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1);
    tick();
    checkOutput("collide_bank_full", 128'(bank_full), 128'(2'b11));
    checkOutput("collide_err", 128'(err), 128'(0));

    $display("[TB] reset mid-fill");
    doReset();
    applyStimulus(1'b1, 8'd4, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) sendBeat(seqBeat(16 * k), pc);
    tick();
    s_valid = 1'b1; s_data = seqBeat(200);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_outputs", 128'({we, s_ready, busy, done, err, bank_sel_wr, bank_full}), 128'(0));
    checkOutput("mid_rst_waddr_wdata", 128'({waddr, wdata}), 128'(0));
    base = wlog.size();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    s_valid = 1'b0;
    checkOutput("mid_rst_no_we", 128'(wlog.size() - base), 128'(0));
    checkOutput("mid_rst_flags", 128'(bank_full), 128'(2'b00));
    applyStimulus(1'b1, 8'd1, 1'b0, 1'b0);
    sendBeat(64'h0F0E_0D0C_0B0A_0908, pc);
    sendBeat(64'h1F1E_1D1C_1B1A_1918, pc);
    repeat (3) tick();
    checkOutput("mid_rst_refill", 128'(wlog.size() - base), 128'(1));
    if (wlog.size() > base) checkOutput("mid_rst_refill_bank", 128'({wlog[base].b, wlog[base].a}), 128'(0));
    checkOutput("mid_rst_refill_full", 128'(bank_full), 128'(2'b01));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the bench can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
